// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM state and MEM/WB record for the MEM stage
package mem_stage_pkg;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_REG_ADDR_W = 3;
  localparam int MEM_TIMEOUT_CYCLES = 64;
  typedef enum logic {IDLE, WAIT} state_e;
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      err;
    logic [MEM_REG_ADDR_W-1:0] wr_reg;
    logic [MEM_DATA_W-1:0]     alu_out;
    logic [MEM_DATA_W-1:0]     rdata;
  } memwb_t;
endpackage

// File: rtl/mem_stage_pipe_memwb_reg.sv
// memwb_reg: MEM/WB pipeline register, active-low sync reset, bubble clears valid/reg_write/err and holds the rest
module memwb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int REG_ADDR_W = MEM_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  valid_d,
  input  logic                  reg_write_d,
  input  logic                  mem_to_reg_d,
  input  logic                  err_d,
  input  logic [REG_ADDR_W-1:0] wr_reg_d,
  input  logic [DATA_W-1:0]     alu_out_d,
  input  logic [DATA_W-1:0]     rdata_d,
  output logic                  valid_q,
  output logic                  reg_write_q,
  output logic                  mem_to_reg_q,
  output logic                  err_q,
  output logic [REG_ADDR_W-1:0] wr_reg_q,
  output logic [DATA_W-1:0]     alu_out_q,
  output logic [DATA_W-1:0]     rdata_q
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      err_q        <= 1'b0;
      wr_reg_q     <= '0;
      alu_out_q    <= '0;
      rdata_q      <= '0;
    end else begin
      valid_q     <= valid_d & ~bubble;
      reg_write_q <= reg_write_d & ~bubble;
      err_q       <= err_d & ~bubble;
      if (!bubble) begin
        mem_to_reg_q <= mem_to_reg_d;
        wr_reg_q     <= wr_reg_d;
        alu_out_q    <= alu_out_d;
        rdata_q      <= rdata_d;
      end
    end
  end
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage driving a req/stall/done data memory and owning MEM/WB; MEM_TIMEOUT_EN adds a WAIT watchdog
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int REG_ADDR_W = MEM_REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_exmem,
  input  logic [DATA_W-1:0]     alu_out_exmem,
  input  logic [DATA_W-1:0]     wr_data_exmem,
  input  logic [REG_ADDR_W-1:0] wr_reg_exmem,
  input  logic                  mem_read_exmem,
  input  logic                  mem_write_exmem,
  input  logic                  reg_write_exmem,
  input  logic                  mem_to_reg_exmem,
  input  logic                  halt_exmem,
  input  logic                  squash_exmem,
  input  logic                  dump_exmem,
  output logic                  dmem_req,
  output logic                  dmem_wr,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic                  dmem_dump,
  input  logic                  dmem_stall,
  input  logic                  dmem_done,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_err,
  output logic                  stall_out,
  output logic                  valid_memwb,
  output logic                  reg_write_memwb,
  output logic                  mem_to_reg_memwb,
  output logic                  err_memwb,
  output logic [DATA_W-1:0]     rdata_memwb,
  output logic [DATA_W-1:0]     alu_out_memwb,
  output logic [REG_ADDR_W-1:0] wr_reg_memwb
);
  localparam int OFF_W = DATA_W > 8 ? $clog2(DATA_W / 8) : 1;
  state_e state_q, state_d;
  logic live, misal, rd, wr, acc, idle, done_ok, tmo, cmpl, err;
  assign live = valid_exmem & ~squash_exmem;
  assign misal = (DATA_W > 8) && (|alu_out_exmem[OFF_W-1:0]);
  assign rd = live & mem_read_exmem & ~misal;
  assign wr = live & mem_write_exmem & ~halt_exmem & ~misal;
  assign acc = rd | wr;
  assign idle = state_q == IDLE;
  assign done_ok = idle ? acc & ~dmem_stall & dmem_done : dmem_done;
  assign cmpl = done_ok | tmo;
  assign stall_out = rst & (idle ? acc & ~done_ok : ~cmpl);
  assign dmem_req = rst & idle & acc;
  assign dmem_wr = wr;
  assign dmem_wdata = wr_data_exmem;
  assign dmem_dump = live & dump_exmem & ~stall_out;
  assign err = live & (misal & (mem_read_exmem | mem_write_exmem) | done_ok & dmem_err | tmo);
  if (ADDR_W > DATA_W) begin : g_addr_ext
    assign dmem_addr = {{(ADDR_W - DATA_W){1'b0}}, alu_out_exmem};
  end else begin : g_addr_trunc
    assign dmem_addr = alu_out_exmem[ADDR_W-1:0];
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = idle ? '0 : cnt_q + 1'b1;
  assign tmo = ~idle & ~dmem_done & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) cnt_q <= rst ? cnt_d : '0;
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_comb state_d = idle ? (acc & ~dmem_stall & ~dmem_done ? WAIT : IDLE) : (cmpl ? IDLE : WAIT);
  always_ff @(posedge clk) state_q <= rst ? state_d : IDLE;
  memwb_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_memwb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (stall_out),
    .valid_d      (live),
    .reg_write_d  (live & reg_write_exmem & ~err),
    .mem_to_reg_d (mem_to_reg_exmem),
    .err_d        (err),
    .wr_reg_d     (wr_reg_exmem),
    .alu_out_d    (alu_out_exmem),
    .rdata_d      (rd & done_ok ? dmem_rdata : '0),
    .valid_q      (valid_memwb),
    .reg_write_q  (reg_write_memwb),
    .mem_to_reg_q (mem_to_reg_memwb),
    .err_q        (err_memwb),
    .wr_reg_q     (wr_reg_memwb),
    .alu_out_q    (alu_out_memwb),
    .rdata_q      (rdata_memwb)
  );
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed stimulus against a per-cycle behavioural model of the MEM stage
module tb_mem_stage_pipe;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic valid_exmem, mem_read_exmem, mem_write_exmem, reg_write_exmem, mem_to_reg_exmem;
  logic halt_exmem, squash_exmem, dump_exmem, dmem_stall, dmem_done, dmem_err;
  logic [15:0] alu_out_exmem, wr_data_exmem, dmem_rdata;
  logic [2:0] wr_reg_exmem;
  logic dmem_req, dmem_wr, dmem_dump, stall_out;
  logic [15:0] dmem_addr, dmem_wdata, rdata_memwb, alu_out_memwb;
  logic valid_memwb, reg_write_memwb, mem_to_reg_memwb, err_memwb;
  logic [2:0] wr_reg_memwb;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_stage_pipe #(.DATA_W(16), .ADDR_W(16), .REG_ADDR_W(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_exmem(valid_exmem), .alu_out_exmem(alu_out_exmem), .wr_data_exmem(wr_data_exmem),
    .wr_reg_exmem(wr_reg_exmem), .mem_read_exmem(mem_read_exmem), .mem_write_exmem(mem_write_exmem),
    .reg_write_exmem(reg_write_exmem), .mem_to_reg_exmem(mem_to_reg_exmem), .halt_exmem(halt_exmem),
    .squash_exmem(squash_exmem), .dump_exmem(dump_exmem),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_dump(dmem_dump), .dmem_stall(dmem_stall), .dmem_done(dmem_done), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err), .stall_out(stall_out),
    .valid_memwb(valid_memwb), .reg_write_memwb(reg_write_memwb), .mem_to_reg_memwb(mem_to_reg_memwb),
    .err_memwb(err_memwb), .rdata_memwb(rdata_memwb), .alu_out_memwb(alu_out_memwb),
    .wr_reg_memwb(wr_reg_memwb)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  bit busy = 1'b0;
  int wcnt = 0;
  logic m_valid = 1'b0, m_rw = 1'b0, m_m2r = 1'b0, m_err = 1'b0;
  logic [2:0] m_wr_reg = '0;
  logic [15:0] m_alu = '0, m_rdata = '0;
  logic e_live, e_mis, e_rd, e_wr, e_acc, e_tmo, e_done, e_stall, e_req, e_err;
  always_comb begin
    e_live = valid_exmem & ~squash_exmem;
    e_mis = alu_out_exmem[0];
    e_rd = e_live & mem_read_exmem & ~e_mis;
    e_wr = e_live & mem_write_exmem & ~halt_exmem & ~e_mis;
    e_acc = e_rd | e_wr;
`ifdef MEM_TIMEOUT_EN
    e_tmo = busy & ~dmem_done & (wcnt == TO - 1);
`else
    e_tmo = 1'b0;
`endif
    e_done = busy ? (dmem_done | e_tmo) : (e_acc & ~dmem_stall & dmem_done);
    e_stall = rst & (busy ? ~e_done : e_acc & ~e_done);
    e_req = rst & ~busy & e_acc;
    e_err = e_live & (e_mis & (mem_read_exmem | mem_write_exmem) | e_done & ~e_tmo & dmem_err | e_tmo);
  end
  always @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0; wcnt <= 0;
      m_valid <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0; m_err <= 1'b0;
      m_wr_reg <= '0; m_alu <= '0; m_rdata <= '0;
    end else begin
      if (e_stall) begin
        m_valid <= 1'b0; m_rw <= 1'b0; m_err <= 1'b0;
      end else begin
        m_valid <= e_live;
        m_alu <= alu_out_exmem;
        m_wr_reg <= wr_reg_exmem;
        m_m2r <= mem_to_reg_exmem;
        m_rdata <= (e_rd & e_done & ~e_tmo) ? dmem_rdata : 16'h0;
        m_err <= e_err;
        m_rw <= e_live & reg_write_exmem & ~e_err;
      end
      wcnt <= busy ? wcnt + 1 : 0;
      busy <= busy ? ~e_done : (e_acc & ~dmem_stall & ~dmem_done);
    end
  end
  always @(negedge clk) begin
    chk("req", dmem_req, e_req);
    chk("stall_out", stall_out, e_stall);
    chk("dump", dmem_dump, e_live & dump_exmem & ~e_stall);
    if (e_req) begin
      chk("addr", dmem_addr, alu_out_exmem);
      chk("wr", dmem_wr, e_wr);
      if (e_wr) chk("wdata", dmem_wdata, wr_data_exmem);
    end
    chk("valid_memwb", valid_memwb, m_valid);
    chk("reg_write_memwb", reg_write_memwb, m_rw);
    chk("err_memwb", err_memwb, m_err);
    if (m_valid) begin
      chk("alu_out_memwb", alu_out_memwb, m_alu);
      chk("wr_reg_memwb", wr_reg_memwb, m_wr_reg);
      chk("mem_to_reg_memwb", mem_to_reg_memwb, m_m2r);
      chk("rdata_memwb", rdata_memwb, m_rdata);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    valid_exmem = 0; alu_out_exmem = 0; wr_data_exmem = 0; wr_reg_exmem = 0;
    mem_read_exmem = 0; mem_write_exmem = 0; reg_write_exmem = 0; mem_to_reg_exmem = 0;
    halt_exmem = 0; squash_exmem = 0; dump_exmem = 0;
    dmem_stall = 0; dmem_done = 0; dmem_rdata = 0; dmem_err = 0;
  endtask
  task automatic load(input logic [15:0] a, input logic [2:0] r);
    idle_in();
    valid_exmem = 1; mem_read_exmem = 1; reg_write_exmem = 1; mem_to_reg_exmem = 1;
    alu_out_exmem = a; wr_reg_exmem = r;
  endtask
  task automatic store(input logic [15:0] a, input logic [15:0] d);
    idle_in();
    valid_exmem = 1; mem_write_exmem = 1; alu_out_exmem = a; wr_data_exmem = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nreq, nst;
    idle_in();
    rst = 0;
    tick(); tick();
    chk("reset_valid", valid_memwb, 0);
    chk("reset_stall", stall_out, 0);
    chk("reset_req", dmem_req, 0);
    rst = 1;
    load(16'h0010, 3'd3); dmem_done = 1; dmem_rdata = 16'hBEEF; #1;
    chk("hit_stall", stall_out, 0);
    chk("hit_req", dmem_req, 1);
    chk("hit_addr", dmem_addr, 16'h0010);
    tick(); idle_in();
    chk("hit_rdata", rdata_memwb, 16'hBEEF);
    chk("hit_reg_write", reg_write_memwb, 1);
    chk("hit_wr_reg", wr_reg_memwb, 3);
    load(16'h0020, 3'd5); nreq = 0; nst = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_done = (i == 3); dmem_rdata = (i == 3) ? 16'h1234 : 16'hDEAD; #1;
      nreq += int'(dmem_req); nst += int'(stall_out);
      tick();
      if (i < 3) chk("miss_bubble", valid_memwb, 0);
    end
    chk("miss_req_cycles", nreq, 1);
    chk("miss_stall_cycles", nst, 3);
    chk("miss_rdata", rdata_memwb, 16'h1234);
    chk("miss_reg_write", reg_write_memwb, 1);
    store(16'h0040, 16'h5A5A); nreq = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_stall = (i < 2); dmem_done = (i == 2); #1;
      if (dmem_req && dmem_wr && dmem_addr == 16'h0040 && dmem_wdata == 16'h5A5A) nreq++;
      tick();
    end
    chk("held_req_cycles", nreq, 3);
    chk("store_reg_write", reg_write_memwb, 0);
    store(16'h0050, 16'h1111); squash_exmem = 1; reg_write_exmem = 1; #1;
    chk("squash_req", dmem_req, 0);
    tick();
    chk("squash_valid", valid_memwb, 0);
    chk("squash_reg_write", reg_write_memwb, 0);
    store(16'h0060, 16'h2222); halt_exmem = 1; #1;
    chk("halt_store_req", dmem_req, 0);
    tick();
    load(16'h0070, 3'd1); halt_exmem = 1; dmem_done = 1; dmem_rdata = 16'h7777; #1;
    chk("halt_load_req", dmem_req, 1);
    tick();
    chk("halt_load_rdata", rdata_memwb, 16'h7777);
    load(16'h0011, 3'd2); #1;
    chk("misal_req", dmem_req, 0);
    chk("misal_stall", stall_out, 0);
    tick();
    chk("misal_err", err_memwb, 1);
    chk("misal_reg_write", reg_write_memwb, 0);
    load(16'h0100, 3'd1); dmem_done = 1; dmem_rdata = 16'hAAAA;
    tick();
    load(16'h0102, 3'd2); dmem_done = 1; dmem_rdata = 16'hBBBB;
    chk("b2b_first", rdata_memwb, 16'hAAAA);
    tick();
    chk("b2b_second", rdata_memwb, 16'hBBBB);
    chk("b2b_valid", valid_memwb, 1);
    load(16'h0104, 3'd4); dmem_done = 1; dmem_err = 1;
    tick();
    chk("dmem_err_err", err_memwb, 1);
    chk("dmem_err_reg_write", reg_write_memwb, 0);
    idle_in(); valid_exmem = 1; dump_exmem = 1; #1;
    chk("dump_pulse", dmem_dump, 1);
    tick();
    load(16'h0200, 3'd6); #1;
    chk("wait_entry_req", dmem_req, 1);
    tick(); #1;
    chk("wait_stall", stall_out, 1);
    chk("wait_req", dmem_req, 0);
    rst = 0; #1;
    chk("rst_in_wait_stall", stall_out, 0);
    chk("rst_in_wait_req", dmem_req, 0);
    tick();
    chk("rst_in_wait_valid", valid_memwb, 0);
    rst = 1; idle_in(); dmem_done = 1; dmem_rdata = 16'hDEAD; #1;
    chk("stale_done_stall", stall_out, 0);
    tick();
    chk("stale_done_valid", valid_memwb, 0);
    load(16'h0210, 3'd7); dmem_done = 1; dmem_rdata = 16'h4321; #1;
    chk("recover_req", dmem_req, 1);
    tick();
    chk("recover_rdata", rdata_memwb, 16'h4321);
`ifdef MEM_TIMEOUT_EN
    load(16'h0300, 3'd1); nst = 0;
    for (int i = 0; i < 5; i++) begin
      #1; nst += int'(stall_out);
      tick();
      if (i == 4) idle_in();
    end
    chk("timeout_stall_cycles", nst, 4);
    chk("timeout_err", err_memwb, 1);
    chk("timeout_reg_write", reg_write_memwb, 0);
`endif
    idle_in();
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised MEM pipeline stage of the 16-bit pipelined core; sits between the EX/MEM and MEM/WB boundaries and owns the MEM/WB register.
- Talks to a multi-cycle data memory (cache/mem_system) over a req/stall/done handshake.
- Freezes upstream stages while an access is outstanding.
- Squashes wrong-path instructions, blocks stores after halt, and reports misaligned accesses and memory errors.

Parameters:
- DATA_W, 16, datapath and memory word width (power of 2, ≥ 8).
- ADDR_W, 16, data-memory byte address width.
- REG_ADDR_W, 3, register-file index width.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- valid_exmem  in  1  EX/MEM holds a real instruction
- alu_out_exmem  in  DATA_W  address / ALU result
- wr_data_exmem  in  DATA_W  store data
- wr_reg_exmem  in  REG_ADDR_W  destination register
- mem_read_exmem, mem_write_exmem, reg_write_exmem, mem_to_reg_exmem  in  1 each  control bits
- halt_exmem, squash_exmem, dump_exmem  in  1 each  halt / wrong-path kill / memory dump
- dmem_req  out  1  access request
- dmem_wr  out  1  1 = write
- dmem_addr  out  ADDR_W  access address
- dmem_wdata  out  DATA_W  write data
- dmem_dump  out  1  dump strobe
- dmem_stall  in  1  memory cannot accept a request this cycle
- dmem_done  in  1  access complete (may coincide with accept)
- dmem_rdata  in  DATA_W  read data, valid with dmem_done
- dmem_err  in  1  error, valid with dmem_done
- stall_out  out  1  freeze PC/IF/ID/EX/EX-MEM
- valid_memwb, reg_write_memwb, mem_to_reg_memwb, err_memwb  out  1 each  MEM/WB control
- rdata_memwb, alu_out_memwb  out  DATA_W  MEM/WB data
- wr_reg_memwb  out  REG_ADDR_W  MEM/WB destination register

Behaviour:
- Reset (rst == 0 at a clk edge):
  - FSM goes to IDLE; all MEM/WB outputs become 0; timeout counter becomes 0.
  - Combinational outputs from the reset cycle onward: dmem_req = 0, stall_out = 0.
  - Reset mid-access abandons the access; any later dmem_done is ignored until a new request is issued.
- Qualifiers:
  - live = valid_exmem & ~squash_exmem
  - misal = (alu_out_exmem[log2(DATA_W/8)-1:0] != 0), for DATA_W > 8
  - rd = live & mem_read_exmem & ~misal
  - wr = live & mem_write_exmem & ~halt_exmem & ~misal
  - acc = rd | wr; if rd and wr are both set, the access is treated as a write.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = acc. dmem_addr = alu_out_exmem[ADDR_W-1:0], zero-extended if ADDR_W > DATA_W. dmem_wr = wr, dmem_wdata = wr_data_exmem.
  - IDLE, accepted (acc & ~dmem_stall): with dmem_done in the same cycle (hit), complete now and stay in IDLE; otherwise go to WAIT.
  - IDLE, acc & dmem_stall: stay in IDLE, re-present an identical request next cycle.
  - WAIT: dmem_req = 0; on dmem_done, complete and go to IDLE.
- stall_out = (IDLE & acc & ~(~dmem_stall & dmem_done)) | (WAIT & ~dmem_done). It is combinational and upstream must hold EX/MEM while it is high.
- MEM/WB update, every clock:
  - stall_out = 1: load a bubble (valid, reg_write, err = 0; other fields don't-care, held).
  - Otherwise load valid = live, alu_out, wr_reg, mem_to_reg, and rdata = dmem_rdata on a completing read (else 0).
  - reg_write = live & reg_write_exmem & ~err.
  - err = live & (misal & (mem_read_exmem | mem_write_exmem) | completing access with dmem_err).
- Squashed instructions never access memory and never write the register file, including when reg_write_exmem = 1.
- Halt blocks stores only; loads under halt still complete.
- dmem_dump = live & dump_exmem & ~stall_out: one pulse per instruction.
- Single-cycle throughput on back-to-back hits; no bubble between consecutive completing accesses.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
  - Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without dmem_done, the access completes as an error (err_memwb = 1, reg_write_memwb = 0) and the FSM returns to IDLE.
  - Undefined: no counter; WAIT persists until dmem_done.

Decomposition:
- Package mem_stage_pkg:
  - state enum {IDLE, WAIT}
  - packed struct memwb_t (valid, reg_write, mem_to_reg, err, wr_reg, alu_out, rdata), parametrised by width localparams.
- One sub-module, memwb_reg: synchronous active-low reset, with bubble-insert input.

Test Plan:
- Load hit: addr 0x0010, dmem_done same cycle, rdata 0xBEEF -> stall_out 0, next cycle rdata_memwb 0xBEEF, reg_write_memwb 1.
- Load miss: dmem_done 3 cycles after request -> stall_out high 3 cycles, dmem_req 1 cycle, three MEM/WB bubbles, then data written back.
- dmem_stall high for 2 cycles -> dmem_req held with the same address and data for 3 cycles until accepted.
- Store with squash_exmem = 1 and reg_write_exmem = 1 -> dmem_req 0, valid_memwb 0, reg_write_memwb 0. Store with halt_exmem = 1 -> dmem_req 0.
- Load at addr 0x0011 -> no request, err_memwb 1, reg_write_memwb 0. Reset asserted in WAIT -> IDLE, outputs 0, stale dmem_done ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no dmem_done -> after 4 WAIT cycles err_memwb 1 and stall_out released.
